// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the instruction fetch unit and its
// next-PC generator.
//   fetch_state_e : fetch FSM states (request, wait for memory, hold, fault)
//   PCSRC_*       : next-PC select encodings produced by the main decoder
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) held in Instr after reset
package core_pkg;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StFault = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A fetch address is legal only on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_gen.sv
// next_pc_gen: combinational next-PC selection and alignment check.
// Ports:
//   i_pc         in  32  address of the instruction being retired
//   i_pc_src     in   2  select: 00/11 = PC+4, 01 = PC+ImmExt, 10 = JALR target
//   i_imm_ext    in  32  sign-extended branch/JAL immediate
//   i_alu_result in  32  rs1+imm for JALR
//   o_next_pc    out 32  selected next PC (additions wrap modulo 2^32)
//   o_misaligned out  1  o_next_pc is not on a 4-byte boundary
module next_pc_gen
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_pc_src,
  input  logic [XLEN-1:0] i_imm_ext,
  input  logic [XLEN-1:0] i_alu_result,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_target;
  logic [XLEN-1:0] w_jalr_target;

  assign w_pc_plus4    = i_pc + XLEN'(4);
  assign w_pc_target   = i_pc + i_imm_ext;
  // JALR drops bit 0 of rs1+imm; bit 1 can still be set and is caught below.
  assign w_jalr_target = i_alu_result & ~XLEN'(1);

  always_comb begin
    o_next_pc = w_pc_plus4;
    case (i_pc_src)
      PCSRC_PLUS4:  o_next_pc = w_pc_plus4;
      PCSRC_TARGET: o_next_pc = w_pc_target;
      PCSRC_JALR:   o_next_pc = w_jalr_target;
      // Reserved encoding falls through to sequential execution.
      default:      o_next_pc = w_pc_plus4;
    endcase
  end

  assign o_misaligned = !is_word_aligned(o_next_pc);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch unit. Owns the program counter and
// the instruction memory port; issues one fetch, holds the returned word for
// decode/execute, then steps the PC according to the decoder's PCSrc.
// Ports:
//   clk              in   1  clock, rising edge
//   reset_n          in   1  asynchronous active-low reset
//   PCSrc            in   2  next-PC select from the decoder
//   ImmExt           in  32  branch/JAL immediate
//   ALUResult        in  32  JALR target (rs1+imm)
//   exec_done        in   1  core finished the held instruction (HOLD only)
//   imem_req         out  1  one-cycle fetch request
//   imem_addr        out 32  fetch address (= PC)
//   imem_rvalid      in   1  instruction memory response valid (WAIT only)
//   imem_rdata       in  32  instruction word
//   Instr            out 32  held instruction
//   instr_valid      out  1  Instr is valid for decode
//   PC               out 32  address of Instr
//   PCPlus4          out 32  PC+4
//   misaligned_fault out  1  sticky misaligned next-PC flag
//   fault_pc         out 32  offending next-PC value
module fetch_unit
  import core_pkg::*;
#(
  // Only 32 is supported.
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            exec_done,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] fault_pc
);

  fetch_state_e    r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic [XLEN-1:0] r_instr, w_instr_d;
  logic [XLEN-1:0] r_fault_pc, w_fault_pc_d;

  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  next_pc_gen #(
    .XLEN (XLEN)
  ) u_next_pc_gen (
    .i_pc         (r_pc),
    .i_pc_src     (PCSrc),
    .i_imm_ext    (ImmExt),
    .i_alu_result (ALUResult),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_instr_d    = r_instr;
    w_fault_pc_d = r_fault_pc;
    case (r_state)
      // Request is combinational from the state, so it lasts exactly one cycle.
      StReq: w_state_d = StWait;
      StWait: begin
        if (imem_rvalid) begin
          w_instr_d = imem_rdata;
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (exec_done) begin
          if (w_misaligned) begin
            // PC stays on the faulting instruction for post-mortem.
            w_fault_pc_d = w_next_pc;
            w_state_d    = StFault;
          end else begin
            w_pc_d    = w_next_pc;
            w_state_d = StReq;
          end
        end
      end
      // Terminal until reset; makes misaligned_fault sticky.
      StFault: w_state_d = StFault;
      default: w_state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StReq;
      r_pc       <= RESET_PC;
      r_instr    <= XLEN'(NOP_INSTR);
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_instr    <= w_instr_d;
      r_fault_pc <= w_fault_pc_d;
    end
  end

  // PC only moves on leaving HOLD, so imem_addr is stable REQ through capture.
  assign imem_req         = (r_state == StReq);
  assign imem_addr        = r_pc;
  assign Instr            = r_instr;
  assign instr_valid      = (r_state == StHold);
  assign PC               = r_pc;
  assign PCPlus4          = r_pc + XLEN'(4);
  assign misaligned_fault = (r_state == StFault);
  assign fault_pc         = r_fault_pc;

endmodule
